stolen_cdc_hsk_rx: RTL and testbench
====================================

// Module: stolen_cdc_hsk_rx
// PURPOSE
//  Destination (responder) end of a 2-phase toggle req/ack CDC link carrying a WIDTH-bit word.
//  Synchronises the source's request toggle, captures the quasi-static source bus,
//  presents it on a local valid/ready port and returns an ack toggle once the word is consumed.
//  Sits in the clk domain of any SoC block receiving bursty control/data words from a foreign clock.
// PARAMETERS
//  WIDTH         32  payload width, >=1
//  DEST_SYNC_FF  4   req synchroniser depth, 2..10
// PORTS
//  clk           in   1      destination clock
//  reset_p       in   1      reset, asynchronous, active-high
//  src_req_tgl   in   1      request toggle from source domain (async; one toggle = one word)
//  src_data      in   WIDTH  source payload (async, held stable by source until ack returns)
//  dest_ack_tgl  out  1      ack toggle to source domain (registered, glitch-free)
//  m_valid       out  1      local word valid
//  m_ready       in   1      local consumer ready
//  m_data        out  WIDTH  local word
//  busy          out  1      1 while a word is held (state HOLD)
//  proto_err     out  1      sticky: source toggled req again before ack; cleared by reset only
// BEHAVIOUR
//  - Reset (async assert, sync deassert by system): sync chain=0, state=IDLE, m_valid=0,
//    m_data=0, dest_ack_tgl=0, busy=0, proto_err=0. Source must reset its req toggle to 0 too.
//  - req_sync = last stage of DEST_SYNC_FF-deep ASYNC_REG/DONT_TOUCH chain on src_req_tgl.
//  - pending = (req_sync != dest_ack_tgl).
//  - FSM IDLE: if pending -> m_data<=src_data, m_valid<=1, -> HOLD. Else stay.
//  - FSM HOLD: if m_valid&&m_ready -> m_valid<=0, dest_ack_tgl<=~dest_ack_tgl, -> IDLE.
//    m_data unchanged while m_valid=1 and after acceptance (holds last word).
//  - Latency: src_req_tgl toggle -> m_valid=1 after DEST_SYNC_FF+1 clk edges (+0..1 for async phase).
//  - Ack toggles on the same edge that clears m_valid; dest_ack_tgl never toggles in IDLE.
//  - Next capture no earlier than one cycle after acceptance (IDLE visited); max 1 word per
//    full round trip. m_ready may be held high continuously.
//  - src_data sampled without synchroniser; integration constrains src_data->m_data
//    max-delay <= (DEST_SYNC_FF-1) clk periods. Data never sampled in HOLD.
//  - Protocol error: req_sync changes value while in HOLD -> proto_err<=1 (sticky);
//    held word, m_valid, ack unaffected. Post-error pending level compare resyncs naturally.
//  - Reset mid-HOLD: word dropped, ack returns to 0; no spurious m_valid after release.
//  - busy == (state==HOLD) == m_valid.
// CONFIGURATION
//  STOLEN_CDC_HSK_RX_PARITY_EN defined:
//   - adds port src_par (in,1: even parity over src_data, same stability rules) and
//     m_par_err (out,1, reset 0).
//   - m_par_err <= ^src_data ^ src_par on the capture edge; valid alongside m_data.
//   - Word still delivered and acked normally; parity is advisory only.
//  Not defined: ports absent, no parity logic; all other behaviour identical.
// TESTING (WIDTH=32, DEST_SYNC_FF=4, src model holds data until synced ack returns)
//  1 reset_p=1 mid-random traffic -> m_valid=0, m_data=0, dest_ack_tgl=0, busy=0, proto_err=0 immediately.
//  2 src_data=32'hDEADBEEF, src_req_tgl 0->1 aligned to clk, m_ready=1 -> m_valid=1 on 5th edge,
//    m_data=32'hDEADBEEF, one cycle later m_valid=0 and dest_ack_tgl=1.
//  3 as 2 with m_ready=0 for 10 cycles -> m_valid/m_data/busy held, dest_ack_tgl stays 0;
//    m_ready=1 -> ack=1 same edge m_valid falls.
//  4 stream 32'h1,32'h2,32'h3 back-to-back -> delivered in order once each; ack 0->1->0->1;
//    proto_err=0.
//  5 in HOLD, toggle src_req_tgl twice more -> proto_err=1 and stays 1 after acceptance;
//    held m_data unchanged.
//  6 reset_p pulse while HOLD with 32'hA5A5A5A5 -> outputs cleared, no re-delivery; next
//    transfer 32'h5A5A5A5A OK. With PARITY_EN: src_par wrong -> m_par_err=1, word still acked.

Source files
------------

// File: rtl/stolen_cdc_hsk_rx.sv
// Destination end of a 2-phase toggle req/ack CDC link: syncs req, captures src_data, hands it out on valid/ready.
// Optional even-parity check on the captured word when STOLEN_CDC_HSK_RX_PARITY_EN is defined.
module stolen_cdc_hsk_rx #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned DEST_SYNC_FF = 4
) (
   input  logic             clk,
   input  logic             reset_p,
   input  logic             src_req_tgl,
   input  logic [WIDTH-1:0] src_data,
`ifdef STOLEN_CDC_HSK_RX_PARITY_EN
   input  logic             src_par,
   output logic             m_par_err,
`endif
   output logic             dest_ack_tgl,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             busy,
   output logic             proto_err
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t state;
   (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *) logic [DEST_SYNC_FF-1:0] req_sync_q;
   logic req_sync;
   logic req_sync_d;
   logic pending;

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         req_sync_q <= '0;
      end else begin
         req_sync_q <= {req_sync_q[DEST_SYNC_FF-2:0], src_req_tgl};
      end
   end

   assign req_sync = req_sync_q[DEST_SYNC_FF-1];
   assign pending  = (req_sync != dest_ack_tgl);
   assign busy     = (state == HOLD);

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         state        <= IDLE;
         m_valid      <= 1'b0;
         m_data       <= '0;
         dest_ack_tgl <= 1'b0;
         proto_err    <= 1'b0;
         req_sync_d   <= 1'b0;
`ifdef STOLEN_CDC_HSK_RX_PARITY_EN
         m_par_err    <= 1'b0;
`endif
      end else begin
         req_sync_d <= req_sync;
         case (state)
            IDLE: begin
               if (pending) begin
                  m_data  <= src_data;
                  m_valid <= 1'b1;
                  state   <= HOLD;
`ifdef STOLEN_CDC_HSK_RX_PARITY_EN
                  m_par_err <= (^src_data) ^ src_par;
`endif
               end
            end
            HOLD: begin
               // Any req edge seen while a word is still held means the source did not wait for ack.
               if (req_sync != req_sync_d) begin
                  proto_err <= 1'b1;
               end
               if (m_valid && m_ready) begin
                  m_valid      <= 1'b0;
                  dest_ack_tgl <= ~dest_ack_tgl;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stolen_cdc_hsk_rx.sv
// Directed self-checking bench for stolen_cdc_hsk_rx (WIDTH=32, DEST_SYNC_FF=4).
module tb_stolen_cdc_hsk_rx;

   logic        clk;
   logic        reset_p;
   logic        src_req_tgl;
   logic [31:0] src_data;
   logic        dest_ack_tgl;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        busy;
   logic        proto_err;
`ifdef STOLEN_CDC_HSK_RX_PARITY_EN
   logic        src_par;
   logic        m_par_err;
`endif

   int checks;
   int failures;
   logic exp_ack;

   stolen_cdc_hsk_rx #(.WIDTH(32), .DEST_SYNC_FF(4)) dut (
      .clk          (clk),
      .reset_p      (reset_p),
      .src_req_tgl  (src_req_tgl),
      .src_data     (src_data),
`ifdef STOLEN_CDC_HSK_RX_PARITY_EN
      .src_par      (src_par),
      .m_par_err    (m_par_err),
`endif
      .dest_ack_tgl (dest_ack_tgl),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .busy         (busy),
      .proto_err    (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Source launches one word; returns after m_valid rises (or the wait budget expires).
   task automatic launch(input logic [31:0] data, input logic ready, input logic par_ok);
      int n;
      src_data    = data;
`ifdef STOLEN_CDC_HSK_RX_PARITY_EN
      src_par     = (^data) ^ ~par_ok;
`endif
      src_req_tgl = ~src_req_tgl;
      m_ready     = ready;
      n = 0;
      while (!m_valid && n < 20) begin
         tick();
         n++;
      end
      chk32("latency", 32'(n), 32'd5);
      chk1("valid_up", m_valid, 1'b1);
      chk32("data_cap", m_data, data);
      chk1("busy_up", busy, 1'b1);
      chk1("ack_idle", dest_ack_tgl, exp_ack);
`ifdef STOLEN_CDC_HSK_RX_PARITY_EN
      chk1("par_err", m_par_err, ~par_ok);
`else
      if (par_ok == 1'b0) $display("note: parity not built in");
`endif
   endtask

   // Holds the word for hold cycles with m_ready low, then accepts it.
   task automatic finish_word(input logic [31:0] data, input int hold);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk1("hold_valid", m_valid, 1'b1);
         chk32("hold_data", m_data, data);
         chk1("hold_ack", dest_ack_tgl, exp_ack);
      end
      m_ready = 1'b1;
      tick();
      exp_ack = ~exp_ack;
      chk1("valid_down", m_valid, 1'b0);
      chk1("ack_tgl", dest_ack_tgl, exp_ack);
      chk1("busy_down", busy, 1'b0);
      chk32("data_kept", m_data, data);
   endtask

   task automatic idle_check(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         tick();
         chk1(tag, m_valid, 1'b0);
      end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      exp_ack     = 1'b0;
      reset_p     = 1'b1;
      src_req_tgl = 1'b0;
      src_data    = '0;
      m_ready     = 1'b0;
`ifdef STOLEN_CDC_HSK_RX_PARITY_EN
      src_par     = 1'b0;
`endif
      tick();
      tick();
      reset_p = 1'b0;

      // 1: random traffic, then asynchronous reset mid-cycle
      for (int i = 0; i < 16; i++) begin
         src_req_tgl = 1'($urandom_range(0, 1));
         m_ready     = 1'($urandom_range(0, 1));
         src_data    = $urandom;
         tick();
      end
      #3;
      reset_p = 1'b1;
      #1;
      chk1("rst_valid", m_valid, 1'b0);
      chk32("rst_data", m_data, 32'h0);
      chk1("rst_ack", dest_ack_tgl, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_perr", proto_err, 1'b0);
      src_req_tgl = 1'b0;
      m_ready     = 1'b0;
      tick();
      tick();
      reset_p = 1'b0;
      exp_ack = 1'b0;
      idle_check("post_rst_idle", 6);

      // 2: single word, consumer always ready
      launch(32'hDEADBEEF, 1'b1, 1'b1);
      finish_word(32'hDEADBEEF, 0);
      idle_check("no_dup2", 8);

      // 3: consumer stalls ten cycles
      launch(32'h12345678, 1'b0, 1'b1);
      finish_word(32'h12345678, 10);
      idle_check("no_dup3", 8);

      // 4: three words back to back
      launch(32'h1, 1'b1, 1'b1);
      finish_word(32'h1, 0);
      launch(32'h2, 1'b1, 1'b1);
      finish_word(32'h2, 0);
      launch(32'h3, 1'b1, 1'b1);
      finish_word(32'h3, 0);
      idle_check("no_dup4", 8);
      chk1("perr_clean", proto_err, 1'b0);

      // 5: source toggles twice more while the word is held
      launch(32'hCAFEF00D, 1'b0, 1'b1);
      src_req_tgl = ~src_req_tgl;
      src_data    = 32'h0BADF00D;
      repeat (7) tick();
      src_req_tgl = ~src_req_tgl;
      repeat (7) tick();
      chk1("perr_set", proto_err, 1'b1);
      chk32("perr_data", m_data, 32'hCAFEF00D);
      chk1("perr_valid", m_valid, 1'b1);
      finish_word(32'hCAFEF00D, 2);
      chk1("perr_sticky", proto_err, 1'b1);
      idle_check("no_dup5", 10);
      chk1("perr_sticky2", proto_err, 1'b1);

      // 6: reset while holding a word, then a clean transfer
      launch(32'hA5A5A5A5, 1'b0, 1'b1);
      repeat (3) tick();
      #2;
      reset_p = 1'b1;
      #1;
      chk1("hrst_valid", m_valid, 1'b0);
      chk32("hrst_data", m_data, 32'h0);
      chk1("hrst_ack", dest_ack_tgl, 1'b0);
      chk1("hrst_busy", busy, 1'b0);
      chk1("hrst_perr", proto_err, 1'b0);
      src_req_tgl = 1'b0;
      m_ready     = 1'b1;
      tick();
      tick();
      reset_p = 1'b0;
      exp_ack = 1'b0;
      idle_check("no_redeliver", 10);
      launch(32'h5A5A5A5A, 1'b1, 1'b1);
      finish_word(32'h5A5A5A5A, 0);
`ifdef STOLEN_CDC_HSK_RX_PARITY_EN
      idle_check("par_idle", 4);
      launch(32'h00000007, 1'b1, 1'b0);
      finish_word(32'h00000007, 0);
`endif
      chk1("end_perr", proto_err, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
